// File: rtl/joy_md6_pad.sv
// joy_md6_pad: Mega Drive 6-button pad emulator; drives the DB9 data pins from the select phase.
module joy_md6_pad #(
  parameter int TIMEOUT = 72000,
  parameter bit SIX_BTN = 1
) (
  input  logic        clk,
  input  logic        I_RESETn,
  input  logic        joy_sel,
  input  logic [11:0] buttons,
  output logic [5:0]  joy_out,
  output logic [2:0]  phase
);
  localparam logic [16:0] TMO = 17'(TIMEOUT);
  logic sel_m, sel_s, sel_d, edg, fall;
  logic [16:0] timer, timer_nx;
  logic [2:0] n_nx;
  logic [5:0] map;
  assign edg = sel_s ^ sel_d;
  assign fall = sel_d & ~sel_s;
  // an edge beats a same-cycle timeout, since timer_nx is then 0
  always_comb begin
    timer_nx = edg ? 17'd0 : (timer == TMO) ? timer : timer + 17'd1;
    n_nx = !SIX_BTN ? 3'd0 : fall ? ((phase == 3'd4) ? 3'd1 : phase + 3'd1) : (timer_nx == TMO) ? 3'd0 : phase;
    map = sel_s ? ((n_nx == 3'd3) ? ~{buttons[6], buttons[5], buttons[11:8]} : ~{buttons[6], buttons[5], buttons[3:0]})
                : {~buttons[7], ~buttons[4], (n_nx == 3'd3) ? 4'b0000 : (n_nx == 3'd4) ? 4'b1111 : {2'b00, ~buttons[1:0]}};
  end
  always_ff @(posedge clk or negedge I_RESETn)
    if (!I_RESETn) begin
      sel_m <= 1'b1;
      sel_s <= 1'b1;
      sel_d <= 1'b1;
      timer <= '0;
      phase <= '0;
      joy_out <= '1;
    end else begin
      sel_m <= joy_sel;
      sel_s <= sel_m;
      sel_d <= sel_s;
      timer <= timer_nx;
      phase <= n_nx;
      joy_out <= map;
    end
endmodule

// File: tb/tb_joy_md6_pad.sv
// tb_joy_md6_pad: table, directed and random checks of the 6-button pad against a burst-counting model.
`timescale 1ns/1ps
module tb_joy_md6_pad;
  localparam int TO = 100;
  logic clk = 0, rst_n = 0, joy_sel = 1;
  logic [11:0] buttons = 12'hFFF;
  logic [5:0] out1, out2;
  logic [2:0] ph1, ph2;
  int checks = 0, errors = 0;
  int cyc = 0, last_edge = 0, falls = 0, bad, h;
  logic p1 = 1, p2 = 1, p3 = 1, cur;

  joy_md6_pad #(.TIMEOUT(TO), .SIX_BTN(1)) dut (.clk(clk), .I_RESETn(rst_n), .joy_sel(joy_sel), .buttons(buttons), .joy_out(out1), .phase(ph1));
  joy_md6_pad #(.TIMEOUT(TO), .SIX_BTN(0)) dut3 (.clk(clk), .I_RESETn(rst_n), .joy_sel(joy_sel), .buttons(buttons), .joy_out(out2), .phase(ph2));

  always #10 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  typedef struct {
    logic s;
    logic [11:0] b;
    int hold;
    logic [5:0] out;
    logic [2:0] ph;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Pin levels a pad shows for a given select level and phase.
  function automatic logic [5:0] pins(input logic s, input int n, input logic [11:0] b);
    if (s) return (n == 3) ? ~{b[6], b[5], b[11], b[10], b[9], b[8]} : ~{b[6], b[5], b[3], b[2], b[1], b[0]};
    if (n == 3) return {~b[7], ~b[4], 4'b0000};
    if (n == 4) return {~b[7], ~b[4], 4'b1111};
    return {~b[7], ~b[4], 2'b00, ~b[1], ~b[0]};
  endfunction

  // One clock: drive at negedge, advance the model at posedge, compare 1 ns later.
  task automatic step(input logic s, input logic [11:0] b, input logic r);
    int n;
    logic lvl;
    @(negedge clk);
    joy_sel = s;
    buttons = b;
    rst_n = r;
    @(posedge clk);
    cyc++;
    lvl = p2;
    if (!r) begin
      p1 = 1; p2 = 1; p3 = 1; falls = 0; last_edge = cyc;
    end else begin
      if (p3 && !p2) falls++;
      if (p2 != p3) last_edge = cyc;
      else if (cyc - last_edge >= TO) falls = 0;
      p3 = p2; p2 = p1; p1 = s;
    end
    n = (falls == 0) ? 0 : 1 + (falls - 1) % 4;
    #1;
    chk("out6", int'(out1), r ? int'(pins(lvl, n, b)) : 'h3F);
    chk("phase6", int'(ph1), n);
    chk("out3", int'(out2), r ? int'(pins(lvl, 0, b)) : 'h3F);
    chk("phase3", int'(ph2), 0);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 12'h900, TO + 5, 6'b111111, 3'd0};
    tbl[1]  = '{1'b0, 12'h900, 10, 6'b110011, 3'd1};
    tbl[2]  = '{1'b1, 12'h900, 10, 6'b111111, 3'd1};
    tbl[3]  = '{1'b0, 12'h900, 10, 6'b110011, 3'd2};
    tbl[4]  = '{1'b1, 12'h900, 10, 6'b111111, 3'd2};
    tbl[5]  = '{1'b0, 12'h900, 10, 6'b110000, 3'd3};
    tbl[6]  = '{1'b1, 12'h900, 10, 6'b110110, 3'd3};
    tbl[7]  = '{1'b0, 12'h900, 10, 6'b111111, 3'd4};
    tbl[8]  = '{1'b1, 12'h900, 10, 6'b111111, 3'd4};
    tbl[9]  = '{1'b0, 12'h900, 10, 6'b110011, 3'd1};
    tbl[10] = '{1'b1, 12'h900, 10, 6'b111111, 3'd1};
    tbl[11] = '{1'b1, 12'h900, TO + 5, 6'b111111, 3'd0};

    repeat (3) step(1, 12'hFFF, 0);
    chk("rst_out", int'(out1), 'h3F);
    chk("rst_phase", int'(ph1), 0);
    step(1, 12'h001, 1);
    chk("rel_up", int'(out1), 'b111110);

    repeat (3) step(0, 12'h090, 1);
    chk("low3_out", int'(out1), 'b000011);
    chk("low3_phase", int'(ph1), 1);

    for (int i = 0; i < 12; i++) begin
      repeat (tbl[i].hold) step(tbl[i].s, tbl[i].b, 1);
      chk($sformatf("tbl%0d_out", i), int'(out1), int'(tbl[i].out));
      chk($sformatf("tbl%0d_phase", i), int'(ph1), int'(tbl[i].ph));
    end

    repeat (10) step(0, 12'h900, 1);
    repeat (10) step(1, 12'h900, 1);
    repeat (10) step(0, 12'h900, 1);
    step(1, 12'h900, 1);
    repeat (TO + 1) step(1, 12'h900, 1);
    chk("tmo_before", int'(ph1), 2);
    step(1, 12'h900, 1);
    chk("tmo_exact", int'(ph1), 0);
    for (int i = 0; i < 3; i++) begin
      repeat (10) step(0, 12'h900, 1);
      if (i < 2) repeat (10) step(1, 12'h900, 1);
    end
    chk("tmo_burst_zeros", int'(out1), 'b110000);

    repeat (TO + 5) step(1, 12'h900, 1);
    repeat (10) step(0, 12'h900, 1);
    step(1, 12'h900, 1);
    repeat (TO - 1) step(1, 12'h900, 1);
    repeat (3) step(0, 12'h900, 1);
    chk("coll_phase", int'(ph1), 2);
    repeat (TO - 1) step(0, 12'h900, 1);
    chk("coll_timer_live", int'(ph1), 2);
    step(0, 12'h900, 1);
    chk("coll_timer_tmo", int'(ph1), 0);

    bad = 0;
    for (int i = 0; i < 10; i++)
      repeat (6) begin
        step(i[0] ? 1'b1 : 1'b0, 12'h800, 1);
        if (out2[3:0] == 4'b0000 || !(out2 == 6'b111111 || out2 == 6'b110011)) bad++;
      end
    chk("six0_pins", bad, 0);
    chk("six0_phase", int'(ph2), 0);

    cur = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 29) == 0) repeat (2) step(cur, 12'($urandom), 0);
      cur = ~cur;
      h = ($urandom_range(0, 15) == 0) ? int'($urandom_range(TO - 3, TO + 20)) : int'($urandom_range(2, 12));
      repeat (h) step(cur, 12'($urandom), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
